// File: rtl/seq_split_lhs_bank.sv
// Per-channel capture bank with a round-robin drain FSM that pushes captured values out and parks them in q.
// Optional sticky overflow flags (ovf port) are built when SEQ_SPLIT_LHS_OVF_EN is defined.
module seq_split_lhs_bank #(
    parameter int              WIDTH     = 8,
    parameter int              CHANNELS  = 4,
    parameter logic [WIDTH-1:0] CLR_VALUE = '0,
    localparam int             CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       clr,
    input  logic [CHANNELS-1:0]       ld,
    input  logic [CHANNELS*WIDTH-1:0] d,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS*WIDTH-1:0] r,
    output logic [CHANNELS-1:0]       r_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [CW-1:0]             out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef SEQ_SPLIT_LHS_OVF_EN
    ,
    output logic [CHANNELS-1:0]       ovf
`endif
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_out_data, w_out_data_next;
    logic [CW-1:0]    r_out_chan, w_out_chan_next;
    logic [CW-1:0]    r_last, w_last_next;
    logic             w_hs;
    logic             w_found;
    int               w_idx;
    logic [CHANNELS-1:0] w_rv;
    logic [WIDTH-1:0]    w_r_arr [CHANNELS];

    assign w_hs      = (r_state == PRESENT) && out_ready;
    assign out_valid = (r_state == PRESENT);
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_out_data <= '0;
            r_out_chan <= '0;
            r_last     <= CW'(CHANNELS - 1);
        end else begin
            r_state    <= w_state_next;
            r_out_data <= w_out_data_next;
            r_out_chan <= w_out_chan_next;
            r_last     <= w_last_next;
        end
    end

    // Scan starts one past the last grant so every pending channel is served before a repeat.
    always_comb begin
        w_state_next    = r_state;
        w_out_data_next = r_out_data;
        w_out_chan_next = r_out_chan;
        w_last_next     = r_last;
        w_found         = 1'b0;
        w_idx           = 0;
        case (r_state)
            IDLE: begin
                for (int j = 1; j <= CHANNELS; j++) begin
                    w_idx = (int'(r_last) + j) % CHANNELS;
                    if (!w_found && w_rv[w_idx]) begin
                        w_found         = 1'b1;
                        w_out_chan_next = CW'(w_idx);
                        w_out_data_next = w_r_arr[w_idx];
                        w_state_next    = PRESENT;
                    end
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                    w_last_next  = r_out_chan;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] r_q_ch;
            logic [WIDTH-1:0] r_r_ch;
            logic             r_rv_ch;
            logic             w_hs_ch;

            assign w_hs_ch = w_hs && (r_out_chan == CW'(gi));

            // clr owns q, ld owns r/r_valid; a handshake drains into q and retires r_valid.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_q_ch  <= CLR_VALUE;
                    r_r_ch  <= '0;
                    r_rv_ch <= 1'b0;
                end else begin
                    if (clr[gi])
                        r_q_ch <= CLR_VALUE;
                    else if (w_hs_ch)
                        r_q_ch <= r_out_data;

                    if (!clr[gi] && ld[gi]) begin
                        r_r_ch  <= d[gi*WIDTH +: WIDTH];
                        r_rv_ch <= 1'b1;
                    end else if (w_hs_ch) begin
                        r_rv_ch <= 1'b0;
                    end
                end
            end

`ifdef SEQ_SPLIT_LHS_OVF_EN
            logic r_ovf_ch;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_ovf_ch <= 1'b0;
                else if (clr[gi])
                    r_ovf_ch <= 1'b0;
                else if (ld[gi] && r_rv_ch && !w_hs_ch)
                    r_ovf_ch <= 1'b1;
            end
            assign ovf[gi] = r_ovf_ch;
`endif

            assign q[gi*WIDTH +: WIDTH] = r_q_ch;
            assign r[gi*WIDTH +: WIDTH] = r_r_ch;
            assign r_valid[gi]          = r_rv_ch;
            assign w_rv[gi]             = r_rv_ch;
            assign w_r_arr[gi]          = r_r_ch;
        end
    endgenerate

endmodule

// File: tb/tb_seq_split_lhs_bank.sv
// Scoreboard bench for seq_split_lhs_bank: a behavioural model predicts register state and drained items.
module tb_seq_split_lhs_bank;
    localparam int W = 8;
    localparam int N = 4;
    localparam int CW = 2;
    localparam logic [W-1:0] CLRV = 8'h3C;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] clr = '0, ld = '0;
    logic [N*W-1:0] d = '0;
    logic [N*W-1:0] q, r;
    logic [N-1:0] r_valid;
    logic [W-1:0] out_data;
    logic [CW-1:0] out_chan;
    logic out_valid;
    logic out_ready = 1'b0;
`ifdef SEQ_SPLIT_LHS_OVF_EN
    logic [N-1:0] ovf;
`endif

    seq_split_lhs_bank #(.WIDTH(W), .CHANNELS(N), .CLR_VALUE(CLRV)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .d(d),
        .q(q), .r(r), .r_valid(r_valid),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef SEQ_SPLIT_LHS_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int chan; logic [W-1:0] data; } exp_t;
    exp_t sb[$];
    int   hs_log[$];
    int   checks = 0;
    int   failures = 0;

    logic [W-1:0] m_q [N];
    logic [W-1:0] m_r [N];
    bit           m_rv [N];
    bit           m_ovf [N];
    bit           m_pres;
    int           m_chan, m_last;
    logic [W-1:0] m_data;

    logic [N*W-1:0] e_q, e_r;
    logic [N-1:0]   e_rv, e_ovf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_q[i] = CLRV; m_r[i] = '0; m_rv[i] = 0; m_ovf[i] = 0;
        end
        m_pres = 0; m_chan = 0; m_last = N - 1; m_data = '0;
        sb.delete();
    endtask

    // One clock edge of the specified behaviour, using the inputs present before the edge.
    task automatic model_step();
        bit           hs, hsi;
        int           k, c;
        logic [W-1:0] old_r [N];
        bit           old_rv [N];
        logic [W-1:0] old_data;
        exp_t         e;
        hs = m_pres && out_ready;
        k = m_chan;
        old_data = m_data;
        for (int i = 0; i < N; i++) begin
            old_r[i] = m_r[i]; old_rv[i] = m_rv[i];
        end
        if (m_pres) begin
            if (hs) begin m_pres = 0; m_last = k; end
        end else begin
            for (int j = 1; j <= N; j++) begin
                c = (m_last + j) % N;
                if (old_rv[c]) begin
                    m_pres = 1; m_chan = c; m_data = old_r[c];
                    e.chan = c; e.data = old_r[c];
                    sb.push_back(e);
                    break;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            hsi = hs && (k == i);
            if (clr[i]) m_q[i] = CLRV;
            else if (hsi) m_q[i] = old_data;
            if (clr[i]) m_ovf[i] = 0;
            else if (ld[i] && old_rv[i] && !hsi) m_ovf[i] = 1;
            if (!clr[i] && ld[i]) begin
                m_r[i] = d[i*W +: W]; m_rv[i] = 1;
            end else if (hsi) begin
                m_rv[i] = 0;
            end
        end
    endtask

    task automatic cyc_in(input logic [N-1:0] c, input logic [N-1:0] l,
                          input logic [N*W-1:0] dd, input logic rdy);
        clr = c; ld = l; d = dd; out_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_in('0, '0, '0, 1'b1);
    endtask

    // Monitor: compares visible state every cycle and pops the scoreboard on each handshake.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e_q[i*W +: W] = m_q[i];
            e_r[i*W +: W] = m_r[i];
            e_rv[i] = m_rv[i];
            e_ovf[i] = m_ovf[i];
        end
        chk("q", q, e_q);
        chk("r", r, e_r);
        chk("r_valid", r_valid, e_rv);
        chk("out_valid", out_valid, m_pres);
`ifdef SEQ_SPLIT_LHS_OVF_EN
        chk("ovf", ovf, e_ovf);
`endif
        if (out_valid && m_pres) begin
            chk("out_chan", out_chan, m_chan);
            chk("out_data", out_data, m_data);
        end
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL hs_unexpected actual=ch%0d/%0h required=none", out_chan, out_data);
            end else begin
                e = sb.pop_front();
                chk("hs_chan", out_chan, e.chan);
                chk("hs_data", out_data, e.data);
            end
            hs_log.push_back(int'(out_chan));
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_q", q, {N{CLRV}});
        chk("rst_r", r, '0);
        chk("rst_rv", r_valid, '0);
        chk("rst_ov", out_valid, 1'b0);

        // Round robin from reset: channel 0 first, one item every 2 cycles.
        hs_log.delete();
        cyc_in('0, 4'b1111, 32'h44332211, 1'b1);
        idle(10);
        chk("rr_len", hs_log.size(), 4);
        for (int i = 0; i < 4 && i < hs_log.size(); i++) chk("rr_order", hs_log[i], i);
        chk("rr_q", q, 32'h44332211);

        // clr and ld together: clr wins, ld ignored.
        cyc_in(4'b0001, 4'b0001, 32'h000000A5, 1'b0);
        chk("sl_q0", q[7:0], CLRV);
        chk("sl_r0", r[7:0], 8'h11);
        chk("sl_rv0", r_valid[0], 1'b0);
        cyc_in('0, 4'b0001, 32'h000000A5, 1'b0);
        chk("sl2_r0", r[7:0], 8'hA5);
        chk("sl2_rv0", r_valid[0], 1'b1);
        chk("sl2_q0", q[7:0], CLRV);
        idle(4);

        // Backpressure on ch2 with a new capture during PRESENT.
        cyc_in('0, 4'b0100, 32'h005D0000, 1'b0);
        cyc_in('0, '0, '0, 1'b0);
        chk("bp_chan", out_chan, 2);
        cyc_in('0, 4'b0100, 32'h007E0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc_in('0, '0, '0, 1'b0);
            chk("bp_hold", out_data, 8'h5D);
        end
        cyc_in('0, 4'b0100, 32'h007E0000, 1'b1);
        chk("bp_q2", q[23:16], 8'h5D);
        chk("bp_rv2", r_valid[2], 1'b1);
        idle(4);
        chk("bp_redrain", q[23:16], 8'h7E);

        // clr collides with the ch1 handshake.
        cyc_in('0, 4'b0010, 32'h00009900, 1'b0);
        cyc_in('0, '0, '0, 1'b0);
        cyc_in(4'b0010, '0, '0, 1'b1);
        chk("col_q1", q[15:8], CLRV);
        chk("col_rv1", r_valid[1], 1'b0);

        // Overwrite on ch3 while pending; sticky until clr.
        cyc_in('0, 4'b1000, 32'hAB000000, 1'b0);
        cyc_in('0, 4'b1000, 32'hCD000000, 1'b0);
`ifdef SEQ_SPLIT_LHS_OVF_EN
        chk("ovf_set", ovf[3], 1'b1);
`endif
        cyc_in('0, '0, '0, 1'b0);
        cyc_in('0, '0, '0, 1'b0);
`ifdef SEQ_SPLIT_LHS_OVF_EN
        chk("ovf_sticky", ovf[3], 1'b1);
`endif
        cyc_in(4'b1000, '0, '0, 1'b1);
`ifdef SEQ_SPLIT_LHS_OVF_EN
        chk("ovf_clr", ovf[3], 1'b0);
`endif

        // Asynchronous reset while presenting.
        cyc_in('0, 4'b0001, 32'h00000055, 1'b0);
        cyc_in('0, '0, '0, 1'b0);
        chk("pre_rst_ov", out_valid, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_ov", out_valid, 1'b0);
        chk("arst_rv", r_valid, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Random traffic.
        for (int t = 0; t < 1500; t++) begin
            logic [N-1:0] rc, rl;
            for (int i = 0; i < N; i++) begin
                rc[i] = ($urandom_range(0, 15) == 0);
                rl[i] = ($urandom_range(0, 2) == 0);
            end
            cyc_in(rc, rl, $urandom, ($urandom_range(0, 9) < 7));
        end
        idle(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
